// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Desc   : Shared types, constants and sizing helpers for dmem_responder.
// Rev    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int LANES     = DEF_WIDTH / 8;
  localparam int CNT_W     = 4;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_count(input int width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_if
// Desc   : Load/store request/ack bus between the CPU and dmem_responder.
// Rev    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic                         req;
  logic                         we;
  logic [WIDTH-1:0]             addr;
  logic [WIDTH-1:0]             wdata;
  logic [lane_count(WIDTH)-1:0] be;
  logic                         ack;
  logic [WIDTH-1:0]             rdata;
  logic                         err;
  logic                         busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err, busy
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module : dmem_array
// Desc   : Single-port word RAM with per-byte write enables and registered read.
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          wr_en,
  input  wire logic                          rd_en,
  input  wire logic [idx_width(DEPTH)-1:0]   idx,
  input  wire logic [WIDTH-1:0]              wdata,
  input  wire logic [lane_count(WIDTH)-1:0]  be,
  output logic      [WIDTH-1:0]              rdata
);

  localparam int LN = lane_count(WIDTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read register only moves on a load commit, so it holds between acks.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LN; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Desc   : Handshaked data-memory slave with programmable wait states.
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int LN    = lane_count(WIDTH);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [LN-1:0]   be_q, be_d;
  logic            fault_q, fault_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [IDX_W-1:0] req_idx;
  logic            req_oor;
  logic            req_fault;

  logic            commit;
  logic            c_we;
  logic [IDX_W-1:0] c_idx;
  logic [WIDTH-1:0] c_wdata;
  logic [LN-1:0]   c_be;
  logic            c_fault;

  logic            wr_en;
  logic            rd_en;

  assign req_idx = bus.addr[IDX_W+1:2];

  generate
    if (IDX_W + 2 < WIDTH) begin : g_range
      assign req_oor = |bus.addr[WIDTH-1:IDX_W+2];
    end else begin : g_norange
      assign req_oor = 1'b0;
    end
  endgenerate

  assign req_fault = (bus.addr[1:0] != 2'b00) || req_oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    fault_d = fault_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    c_fault = fault_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          idx_d   = req_idx;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          fault_d = req_fault;
          cnt_d   = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            // Zero wait states: commit straight from the live bus.
            state_d = RESP;
            commit  = 1'b1;
            c_we    = bus.we;
            c_idx   = req_idx;
            c_wdata = bus.wdata;
            c_be    = bus.be;
            c_fault = req_fault;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit) begin
      ack_d = 1'b1;
      err_d = c_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      fault_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      fault_q <= fault_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the commit edge must not write or read.
  assign wr_en = commit &&  c_we && !c_fault && !reset;
  assign rd_en = commit && !c_we && !c_fault && !reset;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (c_idx),
    .wdata (c_wdata),
    .be    (c_be),
    .rdata (bus.rdata)
  );

  // Reset during the response cycle withdraws the ack; the write already landed.
  assign bus.ack  = ack_q && !reset;
  assign bus.err  = err_q && !reset;
  assign bus.busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's load/store port, replacing the zero-latency single-cycle data memory with a handshaked slave.
- Accepts one request at a time on a req/ack interface and inserts a programmable number of wait states.
- Supports byte-enable writes and registered read data, and flags misaligned or out-of-range accesses.
- Sits between cpu_datapath (initiator) and the word-organised storage array.

Parameters:
- WIDTH, 32, data and address width in bits; must be a multiple of 8.
- DEPTH, 256, number of WIDTH-bit words in the array; must be a power of 2.
- LATENCY, 2, wait-state cycles between request acceptance and ack (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid; held with addr/we/wdata/be stable until ack.
- we  input  1  1 = store, 0 = load.
- addr  input  WIDTH  byte address.
- wdata  input  WIDTH  store data.
- be  input  WIDTH/8  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
- ack  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  load data; valid in the ack cycle, held until the next ack.
- err  output  1  asserted only with ack; access faulted and no write performed.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset: state=IDLE; ack=0; err=0; busy=0; rdata=0; wait counter=0. Array contents are not cleared.
- Reset has priority over every other event. Reset during WAIT aborts the access with no write. Reset in the RESP cycle suppresses ack, but a write already committed stays committed.
- Address decode:
  - word index = addr[$clog2(DEPTH)+1:2].
  - Misaligned when addr[1:0]!=0.
  - Out of range when any bit addr[WIDTH-1:$clog2(DEPTH)+2] is set.
  - fault = misaligned OR out of range.
- IDLE:
  - busy=0.
  - If req=1: latch addr, we, wdata, be and fault; load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, next state is RESP.
  - Input changes during WAIT are ignored; latched values are used.
- Transition into RESP (commit edge):
  - Store, no fault: write the array word, updating only the lanes with latched be=1.
  - Load, no fault: rdata <= array word.
  - Fault: no write, rdata unchanged.
- RESP: ack=1 and err=fault for exactly this one cycle; next state is IDLE.
- Latency: ack is asserted LATENCY+1 cycles after the cycle in which req is sampled in IDLE. With LATENCY=0, ack comes on the cycle after acceptance.
- Initiator rule: deassert req, or present the next request, in the cycle after ack. IDLE does not sample req during RESP, so back-to-back requests cost one IDLE cycle and the throughput bound is one access per LATENCY+2 cycles.
- A store with be=0 completes normally with ack=1, err=0 and no change to the array.
- ack and err are registered outputs and never combinational from req.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Function for the word-index width from DEPTH.
  - Constant for the byte-lane count WIDTH/8.
- One sub-module, dmem_array:
  - Single-port synchronous RAM with per-byte write enables and registered read.
  - Instantiated once.
  - Keeps the FSM/handshake logic separate from storage.

Test Plan:
- LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load addr=0x10 -> each ack exactly 3 cycles after req accepted; load rdata=0xDEADBEEF, err=0.
- Byte-lane store: after word 0x10=0xDEADBEEF, store wdata=0x000000AA, be=4'b0001, then load -> rdata=0xDEADBEAA.
- Faults: load addr=0x12 (misaligned) -> ack with err=1, rdata unchanged. Store addr=0x400 with DEPTH=256 -> err=1, and readback of word 0 is unchanged.
- LATENCY=0: back-to-back loads of 0x0 and 0x4 with req held high -> acks 2 cycles apart, busy alternating 1/0.
- Reset mid-WAIT: store 0x55555555 to 0x20, reset asserted one cycle after acceptance -> no ack, busy=0; later load of 0x20 returns the prior contents.
- Inputs changed during WAIT (addr 0x10 to 0x14) -> access uses the latched 0x10.
